// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n iterations; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mul_acc_adder.sv
// Ripple add/subtract for the accumulator: W-bit operands, W+1-bit result keeping the carry.
// With MUL_SIGNED_EN the top result bit is the sign of the extended sum instead of the raw carry.
module mul_acc_adder #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W:0]   o_sum
);

    logic [W-1:0] w_b_eff;
    logic         w_c;

    always_comb begin
        w_b_eff = i_b ^ {W{i_sub}};
        w_c     = i_sub;
        o_sum   = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = i_a[i] ^ w_b_eff[i] ^ w_c;
            w_c      = (i_a[i] & w_b_eff[i]) | (w_c & (i_a[i] ^ w_b_eff[i]));
        end
`ifdef MUL_SIGNED_EN
        // Bit W of the sign-extended sum: both operands extend with their MSB.
        o_sum[W] = i_a[W-1] ^ w_b_eff[W-1] ^ w_c;
`else
        o_sum[W] = w_c;
`endif
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier behind a start/ready/done handshake, one multiplier bit per cycle.
// Optional build macro MUL_SIGNED_EN selects two's-complement operands (subtract on the MSB step).
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter  int unsigned A_W = 3,
    parameter  int unsigned B_W = 4,
    localparam int unsigned P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] product
);

    localparam int unsigned      CNT_W    = cnt_w(B_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [A_W-1:0]   r_mcand;
    logic [B_W-1:0]   r_mplier;
    logic [A_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [P_W-1:0]   r_product;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [A_W-1:0]   w_addend;
    logic             w_sub;
    logic [A_W:0]     w_sum;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start only counts while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = (r_cnt == CNT_LAST);
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_addend = r_mplier[0] ? r_mcand : '0;

`ifdef MUL_SIGNED_EN
    // The multiplier MSB carries negative weight, so its step subtracts.
    assign w_sub = w_last & r_mplier[0];
`else
    assign w_sub = 1'b0;
`endif

    mul_acc_adder #(
        .W (A_W)
    ) u_adder (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .i_sub (w_sub),
        .o_sum (w_sum)
    );

    // Datapath: {sum, mplier} shifts right once per RUN cycle; the product is the final {acc, mplier}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (w_accept) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == RUN) begin
                r_acc    <= w_sum[A_W:1];
                r_mplier <= {w_sum[0], r_mplier[B_W-1:1]};
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (r_state == DONE) begin
                r_product <= {r_acc, r_mplier};
            end
        end
    end

    // Handshake outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (r_state == DONE);
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: driver queues expected products, a monitor checks them on done.
module tb_seq_shift_add_multiplier;

    localparam int unsigned A_W = 3;
    localparam int unsigned B_W = 4;
    localparam int unsigned P_W = A_W + B_W;

    typedef struct {
        logic [P_W-1:0] p;
        int             due;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [P_W-1:0] product;

    exp_t           sb[$];
    logic [P_W-1:0] exp_hold;
    int             n_cyc;
    int             n_chk;
    int             n_err;
    int             junk_mode;

    seq_shift_add_multiplier #(
        .A_W (A_W),
        .B_W (B_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [P_W-1:0] model(input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
        longint x;
        longint y;
`ifdef MUL_SIGNED_EN
        x = longint'($signed(av));
        y = longint'($signed(bv));
`else
        x = longint'(av);
        y = longint'(bv);
`endif
        return P_W'(x * y);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, n_cyc);
        end
    endtask

    // Watches outputs on the falling edge; expected handshake timing comes from the head of the queue.
    task automatic monitor();
        int  d;
        bit  exp_ready;
        bit  exp_busy;
        forever begin
            @(negedge clk);
            n_cyc++;
            if (!rst_n) begin
                sb.delete();
                exp_hold = '0;
            end else begin
                exp_ready = 1'b1;
                exp_busy  = 1'b0;
                if (sb.size() > 0) begin
                    d = sb[0].due;
                    if (n_cyc >= d - int'(B_W) - 1 && n_cyc <= d - 1) exp_ready = 1'b0;
                    if (n_cyc >= d - int'(B_W) - 1 && n_cyc <= d - 2) exp_busy = 1'b1;
                end
                check("ready", longint'(ready), longint'(exp_ready));
                check("busy", longint'(busy), longint'(exp_busy));
                if (done) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", longint'(done), 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("done_latency", longint'(n_cyc), longint'(e.due));
                        check("product", longint'(product), longint'(e.p));
                        exp_hold = e.p;
                    end
                end else begin
                    check("product_hold", longint'(product), longint'(exp_hold));
                    if (sb.size() > 0 && n_cyc >= sb[0].due) begin
                        check("done_missing", longint'(done), 1);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    endtask

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic drive_cycle(input bit want, input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                               output bit accepted);
        accepted = 1'b0;
        if (ready) begin
            start = want;
            if (want) begin
                a = av;
                b = bv;
                sb.push_back('{p: model(av, bv), due: n_cyc + int'(B_W) + 3});
                accepted = 1'b1;
            end else begin
                a = A_W'($urandom);
                b = B_W'($urandom);
            end
        end else begin
            case (junk_mode)
                0: start = 1'b0;
                1: begin
                    start = 1'b1;
                    a     = A_W'(1);
                    b     = B_W'(1);
                end
                default: begin
                    start = 1'($urandom_range(0, 1));
                    a     = A_W'($urandom);
                    b     = B_W'($urandom);
                end
            endcase
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive_cycle(1'b0, '0, '0, acc);
    endtask

    task automatic issue(input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            drive_cycle(1'b1, av, bv, acc);
            tries++;
        end
        check("accept", longint'(acc), 1);
    endtask

    initial begin
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        int             guard;
        n_cyc     = 0;
        n_chk     = 0;
        n_err     = 0;
        junk_mode = 0;
        exp_hold  = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", longint'(ready), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_product", longint'(product), 0);
        idle(2);

        issue(3'd7, 4'd15);
        idle(8);
        issue(3'd5, 4'd0);
        issue(3'd0, 4'd9);

        // Start held during RUN must be ignored; the next request lands on the first ready cycle.
        junk_mode = 1;
        issue(3'd7, 4'd15);
        issue(3'd3, 4'd6);
        junk_mode = 0;

        issue(3'b100, 4'b1000);
        issue(3'b011, 4'b1111);
        issue(3'b111, 4'b1111);
        idle(8);

        // Abort in the second RUN cycle.
        issue(3'd6, 4'd5);
        idle(1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", longint'(ready), 1);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_product", longint'(product), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        junk_mode = 2;
        for (int i = 0; i < 150; i++) begin
            ra = A_W'($urandom);
            rb = B_W'($urandom);
            if (i % 10 == 0) begin
                ra = '1;
                rb = '1;
            end else if (i % 10 == 1) begin
                ra = '0;
            end
            issue(ra, rb);
            idle(int'($urandom_range(0, 3)));
        end
        junk_mode = 0;

        guard = 0;
        while (sb.size() > 0 && guard < 40) begin
            idle(1);
            guard++;
        end
        check("drain", longint'(sb.size()), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
